// File: rtl/qpu_ifu_pc_fetch_pkg.sv
// qpu_ifu_pc_fetch_pkg
//   Shared constants and state types for the IFU fetch sequencer.
//   QPU_PC_SIZE       default fetch PC width
//   QPU_IFU_IRQ_DEPTH default instruction-queue depth
//   QPU_IFU_PC_STEP   byte increment between sequential fetches
package qpu_ifu_pc_fetch_pkg;

    localparam int unsigned QPU_PC_SIZE       = 32;
    localparam int unsigned QPU_IFU_IRQ_DEPTH = 2;
    localparam int unsigned QPU_IFU_PC_STEP   = 4;

    // Whether a fetch request is in flight awaiting its response.
    typedef enum logic {
        CREDIT_FREE = 1'b0,
        CREDIT_BUSY = 1'b1
    } credit_e;

    // Whether the in-flight response belongs to a pre-redirect request.
    typedef enum logic {
        RSP_LIVE  = 1'b0,
        RSP_STALE = 1'b1
    } stale_e;

endpackage

// File: rtl/qpu_ifu_irq_fifo.sv
// qpu_ifu_irq_fifo
//   Small synchronous FIFO holding {pc, instr} pairs between fetch and decode.
//   Ports:
//     clk, rst         clock, synchronous active-high reset
//     flush            empties the FIFO (wins over push/pop)
//     push, push_data  write side; a push while full is taken only with a pop
//     pop, pop_data    read side; pop_data is the head entry
//     full, empty      occupancy flags
//     count            current number of entries
module qpu_ifu_irq_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic              do_push;
    logic              do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count    = wr_ptr_q - rd_ptr_q;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_data;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/qpu_ifu_pc_fetch.sv
// qpu_ifu_pc_fetch
//   Fetch sequencer: issues fetch PCs with a sequential flag, accepts 32-bit
//   responses, queues {pc, instr} for decode and handles redirects, dropping
//   responses that belong to requests issued before a redirect.
//   Optional feature macro: QPU_IFU_IRQ_BYPASS_EN (response forwarded to decode
//   in the same cycle when the queue is empty and decode is ready).
//   Ports:
//     clk, rst                        clock, synchronous active-high reset
//     redirect_valid, redirect_pc     one-cycle redirect/flush with new PC
//     ifu_req_valid/ready/pc/seq      fetch request channel
//     ifu_rsp_valid/ready/instr       fetch response channel
//     ir_valid/ready/instr/pc         instruction output to decode
module qpu_ifu_pc_fetch
    import qpu_ifu_pc_fetch_pkg::*;
#(
    parameter int unsigned         PC_SIZE   = QPU_PC_SIZE,
    parameter logic [PC_SIZE-1:0]  RESET_PC  = '0,
    parameter int unsigned         IRQ_DEPTH = QPU_IFU_IRQ_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [PC_SIZE-1:0] redirect_pc,
    output logic               ifu_req_valid,
    input  logic               ifu_req_ready,
    output logic [PC_SIZE-1:0] ifu_req_pc,
    output logic               ifu_req_seq,
    input  logic               ifu_rsp_valid,
    output logic               ifu_rsp_ready,
    input  logic [31:0]        ifu_rsp_instr,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [31:0]        ir_instr,
    output logic [PC_SIZE-1:0] ir_pc
);

    localparam int unsigned CW = $clog2(IRQ_DEPTH) + 1;

    logic [PC_SIZE-1:0]    fetch_pc_q, fetch_pc_d;
    logic [PC_SIZE-1:0]    last_pc_q, last_pc_d;
    logic                  seq_q, seq_d;
    credit_e               credit_q, credit_d;
    stale_e                stale_q, stale_d;

    logic                  rsp_hs;
    logic                  req_hs;
    logic                  push;
    logic                  pop;
    logic                  bypass_take;
    logic                  busy_after;
    logic [CW-1:0]         free_after_push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [PC_SIZE+31:0]   fifo_dout;

    assign ifu_rsp_ready = 1'b1;
    assign rsp_hs        = ifu_rsp_valid && ifu_rsp_ready;
    assign ifu_req_pc    = fetch_pc_q;
    assign ifu_req_seq   = seq_q;

    // Queue push/pop and decode-facing outputs.
    always_comb begin
        bypass_take = 1'b0;
`ifdef QPU_IFU_IRQ_BYPASS_EN
        bypass_take = fifo_empty && ir_ready && (stale_q == RSP_LIVE) && !redirect_valid;
        ir_valid    = !rst && (!fifo_empty || (bypass_take && ifu_rsp_valid));
        ir_instr    = fifo_empty ? ifu_rsp_instr : fifo_dout[31:0];
        ir_pc       = fifo_empty ? last_pc_q     : fifo_dout[PC_SIZE+31:32];
`else
        ir_valid    = !rst && !fifo_empty;
        ir_instr    = fifo_dout[31:0];
        ir_pc       = fifo_dout[PC_SIZE+31:32];
`endif
        push = rsp_hs && (stale_q == RSP_LIVE) && !redirect_valid && !bypass_take;
        pop  = ir_ready && !fifo_empty && !redirect_valid;
    end

    // Credit: a response handshaking this cycle retires the outstanding
    // request and takes its slot, so the next request can go back-to-back.
    always_comb begin
        busy_after      = (credit_q == CREDIT_BUSY) && !rsp_hs;
        free_after_push = CW'(IRQ_DEPTH) - fifo_count - CW'(push);
        ifu_req_valid   = !rst && !redirect_valid && !fifo_full && !busy_after
                          && (free_after_push != '0);
        req_hs          = ifu_req_valid && ifu_req_ready;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        last_pc_d  = last_pc_q;
        seq_d      = seq_q;
        credit_d   = credit_q;
        stale_d    = stale_q;
        if (rsp_hs) begin
            credit_d = CREDIT_FREE;
            stale_d  = RSP_LIVE;
        end
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~PC_SIZE'(3);
            seq_d      = 1'b0;
            // The in-flight request's response will still arrive; mark it for drop.
            if ((credit_q == CREDIT_BUSY) && !rsp_hs) begin
                stale_d = RSP_STALE;
            end
        end else if (req_hs) begin
            credit_d   = CREDIT_BUSY;
            last_pc_d  = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_SIZE'(QPU_IFU_PC_STEP);
            seq_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            last_pc_q  <= RESET_PC;
            seq_q      <= 1'b0;
            credit_q   <= CREDIT_FREE;
            stale_q    <= RSP_LIVE;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            last_pc_q  <= last_pc_d;
            seq_q      <= seq_d;
            credit_q   <= credit_d;
            stale_q    <= stale_d;
        end
    end

    qpu_ifu_irq_fifo #(
        .DEPTH (IRQ_DEPTH),
        .WIDTH (PC_SIZE + 32)
    ) u_irq (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({last_pc_q, ifu_rsp_instr}),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_qpu_ifu_pc_fetch.sv
// tb_qpu_ifu_pc_fetch
//   Scoreboard bench for qpu_ifu_pc_fetch. A driver issues directed and random
//   stimulus, a reference model predicts request behaviour and the expected
//   decode stream, and a monitor pops that stream whenever decode takes an
//   instruction.
module tb_qpu_ifu_pc_fetch;

    localparam int unsigned PCW   = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned TOTAL = 3000;
`ifdef QPU_IFU_IRQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            redirect_valid;
    logic [PCW-1:0]  redirect_pc;
    logic            ifu_req_valid;
    logic            ifu_req_ready;
    logic [PCW-1:0]  ifu_req_pc;
    logic            ifu_req_seq;
    logic            ifu_rsp_valid;
    logic            ifu_rsp_ready;
    logic [31:0]     ifu_rsp_instr;
    logic            ir_valid;
    logic            ir_ready;
    logic [31:0]     ir_instr;
    logic [PCW-1:0]  ir_pc;

    qpu_ifu_pc_fetch #(
        .PC_SIZE   (PCW),
        .RESET_PC  (32'h0000_0000),
        .IRQ_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_req_pc     (ifu_req_pc),
        .ifu_req_seq    (ifu_req_seq),
        .ifu_rsp_valid  (ifu_rsp_valid),
        .ifu_rsp_ready  (ifu_rsp_ready),
        .ifu_rsp_instr  (ifu_rsp_instr),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .ir_instr       (ir_instr),
        .ir_pc          (ir_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ir_t;

    ir_t          exp_q[$];
    int unsigned  checks = 0;
    int unsigned  passed = 0;
    int unsigned  ir_pops = 0;

    // Reference model state.
    logic [31:0]  exp_pc;
    bit           exp_seq;
    bit           pending;
    bit           pend_stale;
    logic [31:0]  pend_pc;
    bit           exp_ir_valid;
    bit           in_reset;
    int unsigned  rsp_wait;
    int unsigned  wait_mode;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Driver: inputs change 1 time unit after the rising edge.
    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ifu_req_ready  = 1'b0;
        ifu_rsp_valid  = 1'b0;
        ifu_rsp_instr  = '0;
        ir_ready       = 1'b0;
        wait_mode      = 0;
        for (int c = 0; c < int'(TOTAL); c++) begin
            @(posedge clk);
            #1;
            rst            = (c < 4) || (c >= 1500 && c < 1503);
            redirect_valid = 1'b0;
            redirect_pc    = '0;
            if (c < 40) begin
                ifu_req_ready = 1'b1; ir_ready = 1'b1; wait_mode = 0;
            end else if (c < 70) begin
                // Decode stalled: queue fills, then one pop frees one slot.
                ifu_req_ready = 1'b1; ir_ready = (c == 60); wait_mode = 0;
            end else if (c < 100) begin
                ifu_req_ready = 1'b1; ir_ready = 1'b1; wait_mode = 0;
                if (c == 75) begin redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; end
                if (c == 90) begin redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; end
            end else if (c < 140) begin
                // Slow responses so a redirect lands while a request is in flight.
                ifu_req_ready = 1'b1; ir_ready = 1'b1; wait_mode = 1;
                if (c == 110 || c == 125) begin
                    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100 + 32'(c);
                end
            end else begin
                ifu_req_ready = ($urandom_range(0, 3) != 0);
                ir_ready      = ($urandom_range(0, 2) != 0);
                wait_mode     = 2;
                if ($urandom_range(0, 39) == 0) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = $urandom;
                end
            end
            if (redirect_valid) ir_ready = 1'b0;
            ifu_rsp_valid = 1'b0;
            if (!rst && pending) begin
                if (rsp_wait == 0) begin
                    ifu_rsp_valid = 1'b1;
                    ifu_rsp_instr = $urandom;
                end else begin
                    rsp_wait = rsp_wait - 1;
                end
            end
        end
        @(posedge clk);
        #2;
        chk("ir_traffic", 32'(ir_pops >= 100), 32'd1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Reference model: request-channel expectations and decode-stream prediction.
    initial begin
        bit rsp_hs, req_hs, push_now, expect_req;
        int len_before;
        forever begin
            @(negedge clk);
            chk("rsp_ready", 32'(ifu_rsp_ready), 32'd1);
            if (rst) begin
                chk("rst_req_valid", 32'(ifu_req_valid), 32'd0);
                chk("rst_ir_valid", 32'(ir_valid), 32'd0);
                exp_pc       = 32'h0000_0000;
                exp_seq      = 1'b0;
                pending      = 1'b0;
                pend_stale   = 1'b0;
                exp_ir_valid = 1'b0;
                in_reset     = 1'b1;
                exp_q.delete();
                continue;
            end
            in_reset   = 1'b0;
            rsp_hs     = ifu_rsp_valid && ifu_rsp_ready;
            req_hs     = ifu_req_valid && ifu_req_ready;
            push_now   = rsp_hs && !pend_stale && !redirect_valid;
            len_before = exp_q.size();
            exp_ir_valid = (len_before > 0) ||
                           (BYP && push_now && ir_ready && len_before == 0);
            // A request may go out only if nothing stays in flight and the
            // queue (including this cycle's arrival) still has room.
            expect_req = !redirect_valid && !(pending && !rsp_hs) &&
                         (len_before + int'(push_now) < int'(DEPTH));
            chk("req_valid", 32'(ifu_req_valid), 32'(expect_req));
            if (ifu_req_valid) begin
                chk("req_pc", ifu_req_pc, exp_pc);
                chk("req_seq", 32'(ifu_req_seq), 32'(exp_seq));
            end
            if (rsp_hs) begin
                if (push_now) exp_q.push_back({pend_pc, ifu_rsp_instr});
                pending    = 1'b0;
                pend_stale = 1'b0;
            end
            if (redirect_valid) begin
                exp_q.delete();
                if (pending) pend_stale = 1'b1;
                exp_pc  = redirect_pc & 32'hFFFF_FFFC;
                exp_seq = 1'b0;
            end else if (req_hs) begin
                pending    = 1'b1;
                pend_stale = 1'b0;
                pend_pc    = exp_pc;
                exp_pc     = exp_pc + 32'd4;
                exp_seq    = 1'b1;
                case (wait_mode)
                    0:       rsp_wait = 0;
                    1:       rsp_wait = 2;
                    default: rsp_wait = $urandom_range(0, 3);
                endcase
            end
        end
    end

    // Monitor: compares every instruction decode takes against the scoreboard.
    initial begin
        ir_t e;
        forever begin
            @(negedge clk);
            #1;
            if (in_reset) continue;
            chk("ir_valid", 32'(ir_valid), 32'(exp_ir_valid));
            if (ir_valid && ir_ready) begin
                if (exp_q.size() == 0) begin
                    chk("ir_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ir_pc", ir_pc, e.pc);
                    chk("ir_instr", ir_instr, e.instr);
                    ir_pops++;
                end
            end
        end
    end

endmodule
